pipe_e_stage: RTL and testbench

Execute stage of the five-stage Y86-64 pipeline. It holds the E pipeline register loaded from decode and runs the ALU. It maintains the condition-code register and evaluates branch/cmov conditions. It feeds `e_cnd`, `E_icode` and `E_dstM` to the pipeline control unit, which in turn drives `E_bubble` and `set_cc` back into this block, and presents `e_valE`/`e_dstE` to forwarding and the M register.

---
 rtl/pipe_pkg.sv | 63 ++++++
 rtl/pipe_alu.sv | 50 +++++
 rtl/pipe_e_stage.sv | 146 ++++++++++++++
 tb/tb_pipe_e_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared Y86-64 pipeline constants and condition evaluation helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  // cc is packed {ZF, SF, OF}
  function automatic logic cond_eval(input logic [2:0] cc, input logic [3:0] ifun);
    logic zf, sf, of;
    zf = cc[2];
    sf = cc[1];
    of = cc[0];
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_alu.sv
// ============================================================================
// Module : pipe_alu
// Brief  : Combinational Y86-64 ALU producing valE and the new {ZF,SF,OF}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_alu
  import pipe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] i_alu_a,
  input  logic [W-1:0] i_alu_b,
  input  logic [3:0]   i_alufun,
  output logic [W-1:0] o_val_e,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);

  logic [W-1:0] w_res;
  logic         w_of;

  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    case (i_alufun)
      ALU_ADD: begin
        w_res = i_alu_b + i_alu_a;
        w_of  = (i_alu_a[W-1] == i_alu_b[W-1]) && (w_res[W-1] != i_alu_a[W-1]);
      end
      ALU_SUB: begin
        w_res = i_alu_b - i_alu_a;
        w_of  = (i_alu_a[W-1] != i_alu_b[W-1]) && (w_res[W-1] != i_alu_b[W-1]);
      end
      ALU_AND: w_res = i_alu_b & i_alu_a;
      ALU_XOR: w_res = i_alu_b ^ i_alu_a;
      default: w_res = '0;
    endcase
  end

  assign o_val_e = w_res;
  assign o_zf    = (w_res == '0);
  assign o_sf    = w_res[W-1];
  assign o_of    = w_of;

endmodule

`default_nettype wire

// File: rtl/pipe_e_stage.sv
// ============================================================================
// Module : pipe_e_stage
// Brief  : Y86-64 execute stage: E register, ALU, CC register, cond logic.
//          Optional bubble counter enabled by defining PIPE_E_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_e_stage
  import pipe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E_bubble,
  input  logic         set_cc,
  input  logic [1:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [3:0]   d_srcA,
  input  logic [3:0]   d_srcB,
  output logic [1:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valA,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_cnd,
`ifdef PIPE_E_PERF_EN
  output logic [31:0]  bubble_cnt,
`endif
  output logic [2:0]   cc
);

  logic [1:0]   r_stat;
  logic [3:0]   r_icode, r_ifun, r_dste, r_dstm, r_srca, r_srcb;
  logic [W-1:0] r_valc, r_vala, r_valb;
  logic [2:0]   r_cc;

  logic [W-1:0] w_alu_a, w_alu_b, w_val_e;
  logic [3:0]   w_alufun;
  logic         w_zf, w_sf, w_of, w_cnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      r_stat  <= SAOK;
      r_icode <= INOP;
      r_ifun  <= 4'd0;
      r_valc  <= '0;
      r_vala  <= '0;
      r_valb  <= '0;
      r_dste  <= RNONE;
      r_dstm  <= RNONE;
      r_srca  <= RNONE;
      r_srcb  <= RNONE;
    end else begin
      r_stat  <= d_stat;
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_valc  <= d_valC;
      r_vala  <= d_valA;
      r_valb  <= d_valB;
      r_dste  <= d_dstE;
      r_dstm  <= d_dstM;
      r_srca  <= d_srcA;
      r_srcb  <= d_srcB;
    end
  end

  // Flags follow the instruction already in E, independent of E_bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc <= 3'b100;
    end else if (set_cc && (r_icode == IOPQ)) begin
      r_cc <= {w_zf, w_sf, w_of};
    end
  end

`ifdef PIPE_E_PERF_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= 32'd0;
    end else if (E_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (r_icode)
      IRRMOVQ, IOPQ:             w_alu_a = r_vala;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: w_alu_a = r_valc;
      ICALL, IPUSHQ:             w_alu_a = {{(W-4){1'b1}}, 4'b1000};
      IRET, IPOPQ:               w_alu_a = {{(W-4){1'b0}}, 4'b1000};
      default:                   w_alu_a = '0;
    endcase
    case (r_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IPUSHQ, IRET, IPOPQ: w_alu_b = r_valb;
      default:                                            w_alu_b = '0;
    endcase
  end

  assign w_alufun = (r_icode == IOPQ) ? r_ifun : ALU_ADD;

  pipe_alu #(.W(W)) u_alu (
    .i_alu_a  (w_alu_a),
    .i_alu_b  (w_alu_b),
    .i_alufun (w_alufun),
    .o_val_e  (w_val_e),
    .o_zf     (w_zf),
    .o_sf     (w_sf),
    .o_of     (w_of)
  );

  assign w_cnd   = cond_eval(r_cc, r_ifun);

  assign E_stat  = r_stat;
  assign E_icode = r_icode;
  assign E_ifun  = r_ifun;
  assign E_valA  = r_vala;
  assign E_dstM  = r_dstm;
  assign E_srcA  = r_srca;
  assign E_srcB  = r_srcb;
  assign e_valE  = w_val_e;
  assign e_cnd   = w_cnd;
  assign e_dstE  = ((r_icode == IRRMOVQ) && !w_cnd) ? RNONE : r_dste;
  assign cc      = r_cc;

endmodule

`default_nettype wire

// File: tb/tb_pipe_e_stage.sv
// ============================================================================
// Module : tb_pipe_e_stage
// Brief  : Directed self-checking bench for pipe_e_stage with a reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_e_stage;
  import pipe_pkg::*;

  localparam int W = 64;

  logic         clk, rst_n, E_bubble, set_cc;
  logic [1:0]   d_stat;
  logic [3:0]   d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [W-1:0] d_valC, d_valA, d_valB;
  logic [1:0]   E_stat;
  logic [3:0]   E_icode, E_ifun, E_dstM, E_srcA, E_srcB, e_dstE;
  logic [W-1:0] E_valA, e_valE;
  logic         e_cnd;
  logic [2:0]   cc;
`ifdef PIPE_E_PERF_EN
  logic [31:0]  bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_e_stage #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble), .set_cc(set_cc),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd),
`ifdef PIPE_E_PERF_EN
    .bubble_cnt(bubble_cnt),
`endif
    .cc(cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]   m_stat;
  logic [3:0]   m_icode, m_ifun, m_dste, m_dstm, m_srca, m_srcb;
  logic [W-1:0] m_valc, m_vala, m_valb;
  logic [2:0]   m_cc;
  logic [31:0]  m_bcnt;

  // Result and {ZF,SF,OF} of an OPQ, using W+1-bit signed arithmetic for OF
  function automatic logic [W+2:0] opq_eval(input logic [3:0] ifun, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   wide;
    logic [W-1:0] res;
    logic         of;
    res = '0;
    of  = 1'b0;
    case (ifun)
      4'd0: begin wide = {b[W-1], b} + {a[W-1], a}; res = wide[W-1:0]; of = wide[W] != wide[W-1]; end
      4'd1: begin wide = {b[W-1], b} - {a[W-1], a}; res = wide[W-1:0]; of = wide[W] != wide[W-1]; end
      4'd2: res = a & b;
      4'd3: res = a ^ b;
      default: res = '0;
    endcase
    return {res, (res == '0), res[W-1], of};
  endfunction

  function automatic logic [W-1:0] model_vale();
    logic [W+2:0] o;
    o = opq_eval(m_ifun, m_vala, m_valb);
    case (m_icode)
      IRRMOVQ:          return m_vala;
      IIRMOVQ:          return m_valc;
      IRMMOVQ, IMRMOVQ: return m_valb + m_valc;
      IOPQ:             return o[W+2:3];
      ICALL, IPUSHQ:    return m_valb - 64'd8;
      IRET, IPOPQ:      return m_valb + 64'd8;
      default:          return '0;
    endcase
  endfunction

  function automatic logic model_cnd();
    logic zf, sf, of;
    {zf, sf, of} = m_cc;
    case (m_ifun)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [W+2:0] o;
    if (!rst_n) begin
      m_stat <= 2'd0; m_icode <= 4'd1; m_ifun <= 4'd0;
      m_valc <= '0; m_vala <= '0; m_valb <= '0;
      m_dste <= 4'hF; m_dstm <= 4'hF; m_srca <= 4'hF; m_srcb <= 4'hF;
      m_cc <= 3'b100; m_bcnt <= 32'd0;
    end else begin
      o = opq_eval(m_ifun, m_vala, m_valb);
      if (set_cc && m_icode == 4'd6) m_cc <= o[2:0];
      if (E_bubble) begin
        m_stat <= 2'd0; m_icode <= 4'd1; m_ifun <= 4'd0;
        m_valc <= '0; m_vala <= '0; m_valb <= '0;
        m_dste <= 4'hF; m_dstm <= 4'hF; m_srca <= 4'hF; m_srcb <= 4'hF;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt <= m_bcnt + 1;
      end else begin
        m_stat <= d_stat; m_icode <= d_icode; m_ifun <= d_ifun;
        m_valc <= d_valC; m_vala <= d_valA; m_valb <= d_valB;
        m_dste <= d_dstE; m_dstm <= d_dstM; m_srca <= d_srcA; m_srcb <= d_srcB;
      end
    end
  end

  always @(negedge clk) begin
    chk("E_stat",  E_stat,  m_stat);
    chk("E_icode", E_icode, m_icode);
    chk("E_ifun",  E_ifun,  m_ifun);
    chk("E_valA",  E_valA,  m_vala);
    chk("E_dstM",  E_dstM,  m_dstm);
    chk("E_srcA",  E_srcA,  m_srca);
    chk("E_srcB",  E_srcB,  m_srcb);
    chk("cc",      cc,      m_cc);
    chk("e_valE",  e_valE,  model_vale());
    chk("e_cnd",   e_cnd,   model_cnd());
    chk("e_dstE",  e_dstE,  (m_icode == 4'd2 && !model_cnd()) ? 4'hF : m_dste);
`ifdef PIPE_E_PERF_EN
    chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic ld(input logic [3:0] icode, input logic [3:0] ifun, input logic [W-1:0] valc,
                    input logic [W-1:0] vala, input logic [W-1:0] valb, input logic [3:0] dste,
                    input logic [3:0] dstm, input logic scc, input logic bub);
    d_stat = icode[1:0]; d_icode = icode; d_ifun = ifun;
    d_valC = valc; d_valA = vala; d_valB = valb;
    d_dstE = dste; d_dstM = dstm; d_srcA = 4'h1; d_srcB = 4'h2;
    set_cc = scc; E_bubble = bub;
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] BIG = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    rst_n = 1'b0;
    ld(4'd6, 4'd1, 64'd0, 64'd5, 64'd9, 4'd3, 4'd5, 1'b1, 1'b1);
    ld(4'd6, 4'd1, 64'd0, 64'd5, 64'd9, 4'd3, 4'd5, 1'b1, 1'b0);
    chk("rst E_icode", E_icode, 4'd1);
    chk("rst cc",      cc,      3'b100);
    chk("rst e_cnd",   e_cnd,   1'b1);
    chk("rst e_valE",  e_valE,  64'd0);
    chk("rst e_dstE",  e_dstE,  4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    ld(4'd6, 4'd0, 64'd0, BIG, BIG, 4'd3, 4'hF, 1'b1, 1'b0);
    chk("add ovf valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    ld(4'd6, 4'd1, 64'd0, 64'd1, 64'd1, 4'd3, 4'hF, 1'b1, 1'b0);
    chk("add ovf cc", cc, 3'b011);
    chk("sub valE", e_valE, 64'd0);
    ld(4'd7, 4'd3, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1, 1'b0);
    chk("sub cc", cc, 3'b100);
    chk("je cnd", e_cnd, 1'b1);
    ld(4'd6, 4'd0, 64'd0, BIG, BIG, 4'd3, 4'hF, 1'b1, 1'b0);
    chk("add2 valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    ld(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("setcc0 cc", cc, 3'b100);
    ld(4'd6, 4'd0, 64'd0, 64'd1, 64'd1, 4'd3, 4'hF, 1'b0, 1'b0);
    ld(4'd2, 4'd2, 64'd0, 64'h55, 64'd0, 4'd3, 4'hF, 1'b1, 1'b0);
    chk("cmov cc", cc, 3'b000);
    chk("cmov cnd", e_cnd, 1'b0);
    chk("cmov dstE", e_dstE, 4'hF);
    chk("cmov valE", e_valE, 64'h55);
    ld(4'd10, 4'd0, 64'd0, 64'd7, 64'h100, 4'd4, 4'hF, 1'b0, 1'b0);
    chk("push valE", e_valE, 64'hF8);
    ld(4'd3, 4'd0, 64'd0, 64'd0, 64'd0, 4'd2, 4'hF, 1'b0, 1'b1);
    chk("bubble icode", E_icode, 4'd1);
`ifdef PIPE_E_PERF_EN
    chk("bubble_cnt one", bubble_cnt, 32'd1);
`endif

    for (int i = 0; i < 16; i++)
      ld(4'd7, i[3:0], 64'h80, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    ld(4'd6, 4'd2, 64'd0, 64'hF0F0, 64'hFF00, 4'd1, 4'hF, 1'b1, 1'b0);
    ld(4'd6, 4'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd1, 4'hF, 1'b1, 1'b0);
    ld(4'd6, 4'd1, 64'd0, 64'h8000_0000_0000_0000, 64'd1, 4'd1, 4'hF, 1'b1, 1'b0);
    ld(4'd6, 4'd5, 64'd0, 64'd3, 64'd4, 4'd1, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      ld(4'd2, i[3:0], 64'd0, 64'h1234, 64'd0, 4'd6, 4'hF, 1'b0, 1'b0);
    ld(4'd3, 4'd0, 64'hABCD, 64'd1, 64'd2, 4'd7, 4'hF, 1'b0, 1'b0);
    ld(4'd5, 4'd0, 64'h10, 64'd1, 64'h200, 4'hF, 4'd8, 1'b0, 1'b0);
    ld(4'd8, 4'd0, 64'h300, 64'd0, 64'h1000, 4'd4, 4'hF, 1'b0, 1'b0);
    ld(4'd9, 4'd0, 64'd0, 64'd0, 64'h1000, 4'd4, 4'hF, 1'b0, 1'b0);
    ld(4'd11, 4'd0, 64'd0, 64'd0, 64'h0FF8, 4'd4, 4'd3, 1'b1, 1'b0);

    ld(4'd6, 4'd0, 64'd0, BIG, BIG, 4'd3, 4'hF, 1'b1, 1'b0);
    ld(4'd6, 4'd3, 64'd0, 64'd1, 64'd2, 4'd3, 4'd5, 1'b1, 1'b0);
    chk("pre-rst cc", cc, 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst E_icode", E_icode, 4'd1);
    chk("midrst E_dstM",  E_dstM,  4'hF);
    chk("midrst cc",      cc,      3'b100);
    chk("midrst e_cnd",   e_cnd,   1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ld(4'd6, 4'd1, 64'd0, 64'd2, 64'd1, 4'd3, 4'hF, 1'b1, 1'b0);
    ld(4'd7, 4'd2, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    ld(4'd1, 4'd0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
